// File: rtl/if_fetch.sv
// Instruction-fetch front end: turns accepted PCs into imem reads, pairs responses with
// their PCs in two FIFOs and presents them to decode; a flush discards all outstanding fetches.
module if_fetch #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic [63:0] pc,
  input  logic        pc_valid,
  input  logic        flush,
  output logic        pc_pause,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [63:0]   pcq_mem [DEPTH];
  logic [31:0]   iq_mem  [DEPTH];

  logic [PW-1:0] pcq_wr_q, pcq_wr_d;
  logic [PW-1:0] iq_wr_q, iq_wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] pcq_cnt_q, pcq_cnt_d;
  logic [CW-1:0] iq_cnt_q, iq_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW:0]   occupancy;
  logic [CW-1:0] flush_drop;
  logic          credit;
  logic          req_fire;
  logic          pop;
  logic          has_inflight;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          rsp_err;

  // Request side
  always_comb begin
    occupancy      = {1'b0, pcq_cnt_q} + {1'b0, drop_cnt_q};
    credit         = occupancy < DEPTH_W;
    // Reset is asynchronous, so gate the request combinationally as well
    imem_req_valid = pc_valid & ~flush & credit & ~core_rst;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid & imem_req_ready;
    pc_pause       = ~req_fire;
  end

  // Response classification
  always_comb begin
    has_inflight = (pcq_cnt_q != iq_cnt_q);
    rsp_drop     = imem_rsp_valid & (drop_cnt_q != '0);
    rsp_keep     = imem_rsp_valid & ~flush & (drop_cnt_q == '0) & has_inflight;
    rsp_err      = imem_rsp_valid & (drop_cnt_q == '0) & ~has_inflight;
  end

  // Output side
  always_comb begin
    if_valid = (iq_cnt_q != '0) & ~flush;
    pop      = if_valid & if_ready;
    if (iq_cnt_q != '0) begin
      if_pc   = pcq_mem[rd_q];
      if_inst = iq_mem[rd_q];
    end else begin
      if_pc   = '0;
      if_inst = '0;
    end
  end

  // Outstanding fetches that a flush turns into drops; a response in the flush cycle
  // retires one of them immediately.
  always_comb begin
    flush_drop = drop_cnt_q + (pcq_cnt_q - iq_cnt_q);
    if (imem_rsp_valid && (flush_drop != '0)) begin
      flush_drop = flush_drop - 1'b1;
    end
  end

  // Next-state for counters and pointers
  always_comb begin
    pcq_cnt_d  = pcq_cnt_q;
    iq_cnt_d   = iq_cnt_q;
    drop_cnt_d = drop_cnt_q;
    pcq_wr_d   = pcq_wr_q;
    iq_wr_d    = iq_wr_q;
    rd_d       = rd_q;
    if (flush) begin
      pcq_cnt_d  = '0;
      iq_cnt_d   = '0;
      drop_cnt_d = flush_drop;
      pcq_wr_d   = '0;
      iq_wr_d    = '0;
      rd_d       = '0;
    end else begin
      if (req_fire) begin
        pcq_cnt_d = pcq_cnt_d + 1'b1;
        pcq_wr_d  = pcq_wr_q + 1'b1;
      end
      if (rsp_keep) begin
        iq_cnt_d = iq_cnt_d + 1'b1;
        iq_wr_d  = iq_wr_q + 1'b1;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
      if (pop) begin
        pcq_cnt_d = pcq_cnt_d - 1'b1;
        iq_cnt_d  = iq_cnt_d - 1'b1;
        rd_d      = rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      pcq_cnt_q  <= '0;
      iq_cnt_q   <= '0;
      drop_cnt_q <= '0;
      pcq_wr_q   <= '0;
      iq_wr_q    <= '0;
      rd_q       <= '0;
    end else begin
      pcq_cnt_q  <= pcq_cnt_d;
      iq_cnt_q   <= iq_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      pcq_wr_q   <= pcq_wr_d;
      iq_wr_q    <= iq_wr_d;
      rd_q       <= rd_d;
    end
  end

  // Payload storage; entries are only read when their count says they are valid
  always_ff @(posedge core_clk) begin
    if (req_fire) begin
      pcq_mem[pcq_wr_q] <= pc;
    end
    if (rsp_keep) begin
      iq_mem[iq_wr_q] <= imem_rsp_data;
    end
  end

  // A response with nothing outstanding is a memory protocol error and is ignored
  rsp_no_inflight: assert property (@(posedge core_clk) disable iff (core_rst) !rsp_err);

  iq_le_pcq: assert property (@(posedge core_clk) disable iff (core_rst)
    iq_cnt_q <= pcq_cnt_q);

  occupancy_le_depth: assert property (@(posedge core_clk) disable iff (core_rst)
    occupancy <= DEPTH_W);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: the bench plays PC generator and instruction memory, and a
// scoreboard of requested fetches is checked against if_* and the request handshake.
module tb_if_fetch;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  logic        core_clk;
  logic        core_rst;
  logic [63:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        pc_pause;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  if_fetch #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .core_clk       (core_clk),
    .core_rst       (core_rst),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .flush          (flush),
    .pc_pause       (pc_pause),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          keep;
  } mem_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    bit          arrived;
  } exp_t;

  mem_t        mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] data_override[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: entered just after a falling edge with inputs already driven
  task automatic step();
    bit          rsp_now;
    bit          credit;
    bit          rv_exp;
    bit          ifv_exp;
    bit          fire;
    int          dropped;
    mem_t        m;
    exp_t        e;
    logic [31:0] d;

    rsp_now        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_q[0].data : 32'h0;
    #1;

    dropped = 0;
    foreach (mem_q[i]) if (!mem_q[i].keep) dropped++;
    credit  = (exp_q.size() + dropped) < DEPTH;
    rv_exp  = pc_valid && !flush && credit;
    ifv_exp = !flush && (exp_q.size() > 0) && exp_q[0].arrived;
    fire    = rv_exp && imem_req_ready;

    check("imem_req_valid", {63'b0, imem_req_valid}, {63'b0, rv_exp});
    check("pc_pause", {63'b0, pc_pause}, {63'b0, !fire});
    if (rv_exp) check("imem_req_addr", imem_req_addr, pc);
    check("if_valid", {63'b0, if_valid}, {63'b0, ifv_exp});
    if (ifv_exp) begin
      check("if_pc", if_pc, exp_q[0].pc);
      check("if_inst", {32'b0, if_inst}, {32'b0, exp_q[0].inst});
    end

    if (flush) begin
      foreach (mem_q[i]) mem_q[i].keep = 1'b0;
      exp_q.delete();
    end else if (ifv_exp && if_ready) begin
      void'(exp_q.pop_front());
    end
    if (rsp_now) begin
      m = mem_q.pop_front();
      if (m.keep) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i].arrived) begin
            exp_q[i].arrived = 1'b1;
            break;
          end
        end
      end
    end
    if (fire) begin
      d      = (data_override.size() > 0) ? data_override.pop_front() : inst_of(pc);
      m.data = d;
      m.due  = cyc + mem_lat;
      m.keep = 1'b1;
      mem_q.push_back(m);
      e.pc      = pc;
      e.inst    = d;
      e.arrived = 1'b0;
      exp_q.push_back(e);
    end

    @(posedge core_clk);
    @(negedge core_clk);
    cyc++;
    if (fire) pc = pc + 64'd4;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    core_rst       = 1'b1;
    pc             = 64'h8000_0000;
    pc_valid       = 1'b1;
    flush          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if_ready       = 1'b0;

    // Reset state, with pc_valid already high
    #3;
    check("rst_if_valid", {63'b0, if_valid}, 64'd0);
    check("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    check("rst_pc_pause", {63'b0, pc_pause}, 64'd1);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_if_inst", {32'b0, if_inst}, 64'd0);
    @(negedge core_clk);
    core_rst = 1'b0;

    // Zero-wait memory streaming into an always-ready decode
    mem_lat  = 1;
    if_ready = 1'b1;
    run(12);
    pc_valid = 1'b0;
    run(4);

    // Decode stalled: exactly DEPTH fetches, then stall; drain when ready rises
    pc       = 64'h8000_0000;
    pc_valid = 1'b1;
    if_ready = 1'b0;
    run(5);
    check("full_pcq_cnt", {{(64-CW){1'b0}}, dut.pcq_cnt_q}, 64'(DEPTH));
    if_ready = 1'b1;
    run(6);
    pc_valid = 1'b0;
    run(4);

    // Memory refusing requests: pause and no pcq push
    pc_valid       = 1'b1;
    imem_req_ready = 1'b0;
    run(3);
    check("noready_pcq_cnt", {{(64-CW){1'b0}}, dut.pcq_cnt_q}, 64'd0);
    imem_req_ready = 1'b1;
    pc_valid       = 1'b0;
    run(1);

    // Two fetches in flight, flushed before either response returns
    mem_lat = 3;
    pc      = 64'h8000_0000;
    data_override.push_back(32'hdead_0001);
    data_override.push_back(32'hdead_0002);
    pc_valid = 1'b1;
    run(2);
    flush = 1'b1;
    pc    = 64'h8000_0100;
    run(1);
    flush = 1'b0;
    check("flush_drop_cnt", {{(64-CW){1'b0}}, dut.drop_cnt_q}, 64'd2);
    run(3);
    pc_valid = 1'b0;
    run(8);
    check("flush_drops_done", {{(64-CW){1'b0}}, dut.drop_cnt_q}, 64'd0);

    // Flush coinciding with a response while the iq holds an instruction
    mem_lat  = 2;
    if_ready = 1'b0;
    pc       = 64'h8000_0200;
    pc_valid = 1'b1;
    run(2);
    pc_valid = 1'b0;
    run(1);
    check("pre_flush_iq_cnt", {{(64-CW){1'b0}}, dut.iq_cnt_q}, 64'd1);
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    check("rsp_flush_drop_cnt", {{(64-CW){1'b0}}, dut.drop_cnt_q}, 64'd0);
    check("rsp_flush_iq_cnt", {{(64-CW){1'b0}}, dut.iq_cnt_q}, 64'd0);
    run(4);

    // Asynchronous reset with the iq full, then restart at the reset vector
    mem_lat  = 1;
    pc       = 64'h8000_0300;
    pc_valid = 1'b1;
    run(4);
    check("pre_rst_iq_cnt", {{(64-CW){1'b0}}, dut.iq_cnt_q}, 64'(DEPTH));
    #2;
    core_rst       = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    check("arst_if_valid", {63'b0, if_valid}, 64'd0);
    check("arst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    check("arst_pc_pause", {63'b0, pc_pause}, 64'd1);
    check("arst_if_pc", if_pc, 64'd0);
    check("arst_if_inst", {32'b0, if_inst}, 64'd0);
    mem_q.delete();
    exp_q.delete();
    data_override.delete();
    @(negedge core_clk);
    @(negedge core_clk);
    core_rst = 1'b0;
    pc       = 64'h8000_0000;
    if_ready = 1'b1;
    run(10);
    pc_valid = 1'b0;
    run(5);
    check("end_if_valid", {63'b0, if_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
